// File: rtl/aes_core_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_core_arbiter_pkg
// Brief   : Shared types and constants for the aes_core arbiter slice.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package aes_core_arbiter_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INIT_ISSUE = 3'd1,
      ST_INIT_WAIT  = 3'd2,
      ST_NEXT_ISSUE = 3'd3,
      ST_NEXT_WAIT  = 3'd4
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_core_arbiter_if
// Brief   : Requester-side request/response bus of the aes_core arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface aes_core_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import aes_core_arbiter_pkg::*;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             req_encdec;
   logic [NUM_REQ*AES_BLOCK_W-1:0] req_key;
   logic [NUM_REQ*AES_BLOCK_W-1:0] req_block;
   logic [NUM_REQ-1:0]             resp_valid;
   logic [AES_BLOCK_W-1:0]         resp_result;

   modport master (
      output req_valid, req_encdec, req_key, req_block,
      input  req_ready, resp_valid, resp_result
   );

   modport slave (
      input  req_valid, req_encdec, req_key, req_block,
      output req_ready, resp_valid, resp_result
   );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_rr_arbiter
// Brief   : Combinational round-robin grant; the rotation pointer lives in the parent.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module aes_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_grant_any
);
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_any = 1'b0;
      w_idx       = '0;
      // Walk from the farthest offset inwards so the nearest valid requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
         if (i_req_valid[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
            o_grant_any    = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : aes_core_arbiter
// Brief   : Shares one aes_core among NUM_REQ requesters, re-expanding keys only on change.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module aes_core_arbiter
   import aes_core_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   aes_core_arbiter_if.slave      req_if,
   input  logic                   key_flush,
   output logic                   busy,
   output logic                   core_encdec,
   output logic                   core_init,
   output logic                   core_next,
   output logic [AES_BLOCK_W-1:0] core_key,
   output logic [AES_BLOCK_W-1:0] core_block,
   input  logic                   core_ready,
   input  logic [AES_BLOCK_W-1:0] core_result,
   input  logic                   core_result_valid
);
   localparam int IDX_W = idx_width(NUM_REQ);
   localparam logic [NUM_REQ-1:0] c_ID0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]       r_rr_ptr, r_cur_id, w_grant_idx;
   logic [NUM_REQ-1:0]     w_grant, r_resp_valid;
   logic                   w_grant_any, w_accept, w_key_hit, w_core_done;
   logic                   r_key_valid, r_cur_encdec, w_sel_encdec;
   logic [AES_BLOCK_W-1:0] r_cur_key, r_cur_block, r_cached_key, r_resp_result;
   logic [AES_BLOCK_W-1:0] w_sel_key, w_sel_block;

   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req_valid (req_if.req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_grant_any (w_grant_any)
   );

   always_comb begin
      w_sel_key    = '0;
      w_sel_block  = '0;
      w_sel_encdec = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_key    = req_if.req_key[i*AES_BLOCK_W +: AES_BLOCK_W];
            w_sel_block  = req_if.req_block[i*AES_BLOCK_W +: AES_BLOCK_W];
            w_sel_encdec = req_if.req_encdec[i];
         end
      end
   end

   assign w_accept    = (r_state == ST_IDLE) && core_ready && w_grant_any;
   // A flush arriving with the accept must still force a fresh expansion.
   assign w_key_hit   = r_key_valid && !key_flush && (w_sel_key == r_cached_key);
   assign w_core_done = core_ready && core_result_valid;

   assign req_if.req_ready   = ((r_state == ST_IDLE) && core_ready) ? w_grant : '0;
   assign req_if.resp_valid  = r_resp_valid;
   assign req_if.resp_result = r_resp_result;
   assign busy        = (r_state != ST_IDLE);
   assign core_key    = r_cur_key;
   assign core_block  = r_cur_block;
   assign core_encdec = r_cur_encdec;

   always_comb begin
      w_state_nxt = r_state;
      core_init   = 1'b0;
      core_next   = 1'b0;
      case (r_state)
         ST_IDLE:       if (w_accept) w_state_nxt = w_key_hit ? ST_NEXT_ISSUE : ST_INIT_ISSUE;
         ST_INIT_ISSUE: begin
            core_init   = 1'b1;
            w_state_nxt = ST_INIT_WAIT;
         end
         ST_INIT_WAIT:  if (core_ready) w_state_nxt = ST_NEXT_ISSUE;
         ST_NEXT_ISSUE: begin
            core_next   = 1'b1;
            w_state_nxt = ST_NEXT_WAIT;
         end
         ST_NEXT_WAIT:  if (w_core_done) w_state_nxt = ST_IDLE;
         default:       w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_key_valid   <= 1'b0;
         r_cached_key  <= '0;
         r_cur_key     <= '0;
         r_cur_block   <= '0;
         r_cur_encdec  <= 1'b0;
         r_cur_id      <= '0;
         r_resp_valid  <= '0;
         r_resp_result <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_resp_valid <= '0;
         if (w_accept) begin
            r_rr_ptr     <= (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
            r_cur_key    <= w_sel_key;
            r_cur_block  <= w_sel_block;
            r_cur_encdec <= w_sel_encdec;
            r_cur_id     <= w_grant_idx;
         end
         if (r_state == ST_INIT_ISSUE) r_cached_key <= r_cur_key;
         // Completing an expansion wins over a flush seen while it was in flight.
         if (r_state == ST_INIT_WAIT && core_ready) r_key_valid <= 1'b1;
         else if (key_flush || r_state == ST_INIT_ISSUE) r_key_valid <= 1'b0;
         if (r_state == ST_NEXT_WAIT && w_core_done) begin
            r_resp_result <= core_result;
            r_resp_valid  <= c_ID0 << r_cur_id;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_aes_core_arbiter
// Brief   : Self-checking bench with a behavioural aes_core and a key-cache reference.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_aes_core_arbiter;
   import aes_core_arbiter_pkg::*;

   localparam int NUM_REQ = 2;
   localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 1'b0;
   logic         reset_n, key_flush, busy, core_encdec, core_init, core_next;
   logic [127:0] core_key, core_block;
   logic         m_ready, m_rv;
   logic [127:0] m_res, m_key;
   int           m_cnt, m_op;
   int           n_init = 0, n_next = 0;
   int           n_vec = 0, n_fail = 0;
   bit           ref_valid;
   logic [127:0] ref_key;
   int           ref_rr;

   aes_core_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   aes_core_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_if            (bus),
      .key_flush         (key_flush),
      .busy              (busy),
      .core_encdec       (core_encdec),
      .core_init         (core_init),
      .core_next         (core_next),
      .core_key          (core_key),
      .core_block        (core_block),
      .core_ready        (m_ready),
      .core_result       (m_res),
      .core_result_valid (m_rv)
   );

   always #5 clk = ~clk;

   // Stand-in cipher: known FIPS-197 vector pair, otherwise a keyed scramble.
   function automatic logic [127:0] fake_aes(input logic [127:0] key, input logic [127:0] blk,
                                             input logic enc);
      if (key == c_K1 && enc && blk == c_P1) return c_C1;
      if (key == c_K1 && !enc && blk == c_C1) return c_P1;
      if (enc) return {blk[94:0], blk[127:95]} ^ key;
      return ~({blk[60:0], blk[127:61]} ^ key);
   endfunction

   // Core model: ciphers with the key captured at its last init, block/encdec read at completion.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ready <= 1'b0; m_rv <= 1'b0; m_res <= '0; m_key <= '0; m_cnt <= 3; m_op <= 0;
      end else if (core_init) begin
         m_ready <= 1'b0; m_rv <= 1'b0; m_key <= core_key; m_cnt <= int'($urandom_range(2, 5)); m_op <= 1;
      end else if (core_next) begin
         m_ready <= 1'b0; m_rv <= 1'b0; m_cnt <= int'($urandom_range(2, 5)); m_op <= 2;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end else if (!m_ready) begin
         m_ready <= 1'b1;
         if (m_op == 2) begin
            m_rv  <= 1'b1;
            m_res <= fake_aes(m_key, core_block, core_encdec);
         end
         m_op <= 0;
      end
   end

   always @(posedge clk) begin
      if (core_init) n_init <= n_init + 1;
      if (core_next) n_next <= n_next + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int id, input bit enc, input logic [127:0] key,
                        input logic [127:0] blk, input bit flush, output bit ok);
      @(negedge clk);
      bus.req_valid[id]                = 1'b1;
      bus.req_encdec[id]               = enc;
      bus.req_key[id*128 +: 128]       = key;
      bus.req_block[id*128 +: 128]     = blk;
      key_flush                        = flush;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (bus.req_ready[id]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) check("ready_onehot", {126'd0, bus.req_ready}, 128'd1 << id);
      else    check("accept_timeout", 0, 1);
      @(negedge clk);
      bus.req_valid[id] = 1'b0;
      key_flush         = 1'b0;
      check("busy_after_accept", {127'd0, busy}, ok ? 1 : 0);
   endtask

   task automatic wait_resp(input int id, input logic [127:0] exp);
      bit got = 1'b0;
      bit prev_done = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.resp_valid != '0) begin
            got = 1'b1;
            break;
         end
         prev_done = m_ready && m_rv && busy;
      end
      if (!got) begin
         check("resp_timeout", 0, 1);
      end else begin
         check("resp_latency", {127'd0, prev_done}, 1);
         check("resp_id", {126'd0, bus.resp_valid}, 128'd1 << id);
         check("resp_data", bus.resp_result, exp);
         check("resp_idle", {127'd0, busy}, 0);
         @(negedge clk);
         check("resp_one_cycle", {126'd0, bus.resp_valid}, 0);
      end
   endtask

   task automatic do_txn(input int id, input bit enc, input logic [127:0] key,
                         input logic [127:0] blk, input bit flush);
      int i0, x0;
      bit ok, exp_init;
      i0 = n_init;
      x0 = n_next;
      if (flush) ref_valid = 1'b0;
      exp_init = !ref_valid || (key != ref_key);
      issue(id, enc, key, blk, flush, ok);
      if (ok) begin
         ref_key = key; ref_valid = 1'b1; ref_rr = (id + 1) % NUM_REQ;
      end
      wait_resp(id, fake_aes(key, blk, enc));
      check("init_count", n_init - i0, {127'd0, exp_init});
      check("next_count", n_next - x0, 1);
   endtask

   initial begin
      logic [127:0] k, b, pool[3];
      logic [127:0] cblk[NUM_REQ];
      bit           cenc[NUM_REQ];
      int           q_id[$];
      logic [127:0] q_res[$];
      int           i0, acc, rsp, pend, g, exp_next;
      bit           ok, got, exp_init;

      reset_n = 1'b0; key_flush = 1'b0;
      bus.req_valid = '0; bus.req_encdec = '0; bus.req_key = '0; bus.req_block = '0;
      ref_valid = 1'b0; ref_key = '0; ref_rr = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", {127'd0, busy}, 0);
      check("rst_ready_resp", {124'd0, bus.req_ready, bus.resp_valid}, 0);
      check("rst_core_ctl", {125'd0, core_init, core_next, core_encdec}, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_block", core_block, 0);
      check("rst_resp_result", bus.resp_result, 0);

      // Core still warming up after reset: no acceptance allowed.
      reset_n = 1'b1;
      bus.req_valid[0] = 1'b1; bus.req_encdec[0] = 1'b1;
      bus.req_key[127:0] = c_K1; bus.req_block[127:0] = c_P1;
      #1;
      check("no_accept_core_not_ready", {126'd0, bus.req_ready}, 0);
      check("idle_not_busy", {127'd0, busy}, 0);

      do_txn(0, 1'b1, c_K1, c_P1, 1'b0);
      do_txn(1, 1'b0, c_K1, c_C1, 1'b0);
      do_txn(1, 1'b1, c_K2, {4{$urandom}}, 1'b0);
      do_txn(1, 1'b0, c_K1, c_C1, 1'b0);
      do_txn(0, 1'b0, c_K1, c_C1, 1'b0);

      // Flush while idle: next request must re-expand.
      @(negedge clk); key_flush = 1'b1;
      @(negedge clk); key_flush = 1'b0;
      ref_valid = 1'b0;
      check("flush_idle_busy", {127'd0, busy}, 0);
      do_txn(1, 1'b0, c_K1, c_C1, 1'b0);

      // Flush while an expansion is outstanding is superseded by its completion.
      i0 = n_init;
      b  = {4{$urandom}};
      issue(0, 1'b1, c_K2, b, 1'b0, ok);
      ref_key = c_K2; ref_valid = 1'b1; ref_rr = 1;
      check("init_pulse_seen", {127'd0, core_init}, 1);
      @(negedge clk); key_flush = 1'b1;
      check("in_init_wait", {126'd0, busy, m_ready}, 2'b10);
      @(negedge clk); key_flush = 1'b0;
      wait_resp(0, fake_aes(c_K2, b, 1'b1));
      check("flush_iw_init", n_init - i0, 1);
      do_txn(1, 1'b0, c_K2, {4{$urandom}}, 1'b0);

      // Contention: both requesters hold valid with one shared key.
      k = {4{$urandom}};
      i0 = n_init;
      exp_init = !ref_valid || (k != ref_key);
      exp_next = ref_rr;
      @(negedge clk);
      for (int r = 0; r < NUM_REQ; r++) begin
         cblk[r] = {4{$urandom}};
         cenc[r] = 1'($urandom_range(0, 1));
         bus.req_valid[r] = 1'b1; bus.req_encdec[r] = cenc[r];
         bus.req_key[r*128 +: 128] = k; bus.req_block[r*128 +: 128] = cblk[r];
      end
      acc = 0; rsp = 0; pend = -1;
      for (int c = 0; c < 1000 && rsp < 6; c++) begin
         #1;
         if (bus.resp_valid != '0) begin
            if (q_id.size() == 0) begin
               check("cont_spurious_resp", {126'd0, bus.resp_valid}, 0);
            end else begin
               check("cont_resp_id", {126'd0, bus.resp_valid}, 128'd1 << q_id[0]);
               check("cont_resp_data", bus.resp_result, q_res[0]);
               void'(q_id.pop_front());
               void'(q_res.pop_front());
               rsp++;
            end
         end
         if (bus.req_ready != '0) begin
            check("cont_grant", {126'd0, bus.req_ready}, 128'd1 << exp_next);
            g = 0;
            for (int r = 0; r < NUM_REQ; r++) if (bus.req_ready[r]) g = r;
            q_id.push_back(g);
            q_res.push_back(fake_aes(k, cblk[g], cenc[g]));
            acc++;
            exp_next = (g + 1) % NUM_REQ;
            pend = g;
         end
         @(negedge clk);
         if (pend >= 0) begin
            if (acc >= 6) begin
               bus.req_valid = '0;
            end else begin
               cblk[pend] = {4{$urandom}};
               cenc[pend] = 1'($urandom_range(0, 1));
               bus.req_encdec[pend] = cenc[pend];
               bus.req_block[pend*128 +: 128] = cblk[pend];
            end
            pend = -1;
         end
      end
      check("cont_resp_count", rsp, 6);
      check("cont_init_count", n_init - i0, {127'd0, exp_init});
      ref_key = k; ref_valid = 1'b1; ref_rr = exp_next;

      // Randomized single-requester traffic over a small key pool.
      pool[0] = c_K1; pool[1] = c_K2; pool[2] = {4{$urandom}};
      for (int t = 0; t < 12; t++) begin
         do_txn(int'($urandom_range(0, NUM_REQ - 1)), 1'($urandom_range(0, 1)),
                pool[$urandom_range(0, 2)], {4{$urandom}}, ($urandom_range(0, 3) == 0));
      end

      // Reset during NEXT_WAIT: operation is abandoned, everything back to reset values.
      b = {4{$urandom}};
      issue(0, 1'b1, c_K2, b, 1'b0, ok);
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (core_next) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("mid_next_seen", {127'd0, got}, 1);
      @(negedge clk);
      check("mid_in_next_wait", {127'd0, busy}, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", {127'd0, busy}, 0);
      check("mid_rst_ctl", {123'd0, core_init, core_next, core_encdec, bus.req_ready}, 0);
      check("mid_rst_key", core_key, 0);
      check("mid_rst_block", core_block, 0);
      check("mid_rst_result", bus.resp_result, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("mid_rst_no_resp", {126'd0, bus.resp_valid}, 0);
      end
      reset_n = 1'b1;
      ref_valid = 1'b0; ref_rr = 0;
      do_txn(1, 1'b1, c_K2, b, 1'b0);

      repeat (3) @(negedge clk);
      check("final_idle", {127'd0, busy}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
